// File: rtl/lzc_seq.sv
// Sequential leading-zero counter: scans a WIDTH-bit operand two bits per cycle, MSB first, and stops at the first set bit.
// Latency: the result is valid k = min(floor(lz/2)+1, WIDTH/2) edges after the accept edge. One operation is in flight at a time.
// Backpressure: in_ready is high only in IDLE. The result is held stable while out_valid & !out_ready. flush aborts everything.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_data is sampled on the accept edge only
//   flush                 synchronous abort; returns to IDLE and drops any result
//   out_valid/out_ready   result handshake; out_count/out_zero are held while stalled
//   busy                  engine is not idle
module lzc_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic             busy
);

    localparam int HALF = WIDTH / 2;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic [1:0] top_pair;
    logic       last_pair;

    assign top_pair  = sh_q[WIDTH-1:WIDTH-2];
    assign last_pair = (idx_q == IW'(HALF - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) state_d = SCAN;
                // The scan ends on the first set bit in the pair, or on the last pair.
                SCAN: if (top_pair != 2'b00 || last_pair) state_d = DONE;
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
    end

    // Datapath next-state logic
    always_comb begin
        sh_d        = sh_q;
        count_d     = count_q;
        idx_d       = idx_q;
        zero_d      = zero_q;
        out_valid_d = (state_d == DONE);
        if (flush) begin
            count_d = '0;
            zero_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sh_d    = in_data;
                        count_d = '0;
                        idx_d   = '0;
                        zero_d  = 1'b0;
                    end
                end
                SCAN: begin
                    if (top_pair[1]) begin
                        // The leading bit of this pair is set, so the count is already final.
                    end else if (top_pair[0]) begin
                        count_d = count_q + CW'(1);
                    end else if (!last_pair) begin
                        count_d = count_q + CW'(2);
                        sh_d    = {sh_q[WIDTH-3:0], 2'b00};
                        idx_d   = idx_q + IW'(1);
                    end else begin
                        count_d = CW'(WIDTH);
                        zero_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q        <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = count_q;
    assign out_zero  = zero_q;

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) out_count <= CW'(WIDTH));
    a_no_overlap:  assert property (@(posedge clk) disable iff (!rst_n) !(in_ready && out_valid));
    c_zero_result: cover property (@(posedge clk) disable iff (!rst_n) out_valid && out_zero);

endmodule

// File: doc/lzc_seq.md
Name: lzc_seq

Overview:
- Multi-cycle leading-zero-count engine that sequences a single 2-bit priority encode/merge step over a WIDTH-bit operand, two bits per cycle, MSB first.
- Stops early on the first set bit.
- Sits beside the hasher datapath as a shared, area-cheap alternative to a full combinational LZC tree.
- Valid/ready on input and output; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand width; must be even and >= 4.
- CW, $clog2(WIDTH)+1, count width; holds 0..WIDTH inclusive.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  engine can accept an operand; high only in IDLE.
- in_data  in  WIDTH  operand; sampled on the accept edge only.
- flush  in  1  synchronous abort; drops in-flight op and any pending result.
- out_valid  out  1  result available; registered.
- out_ready  in  1  consumer takes result.
- out_count  out  CW  number of leading zeros of the accepted operand.
- out_zero  out  1  operand was all zeros; out_count == WIDTH in that case.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE, shift register=0, count=0, pair index=0, out_valid=0, out_count=0, out_zero=0, busy=0.
  - in_ready reads 1 once in IDLE; no acceptance while rst_n is low.
- States: IDLE, SCAN, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready edge: load shift reg <= in_data, count <= 0, idx <= 0, go to SCAN.
- SCAN: inspect shift reg top two bits {b1,b0}.
  - 1x: go to DONE; count unchanged.
  - 01: count += 1, go to DONE.
  - 00 with idx < WIDTH/2-1: count += 2, shift left by 2, idx += 1, stay in SCAN.
  - 00 with idx == WIDTH/2-1: count = WIDTH, out_zero <= 1, go to DONE.
- DONE: out_valid=1; out_count and out_zero are stable and unchanged while out_valid & !out_ready.
  - On out_ready edge: out_valid <= 0, go to IDLE.
  - in_ready is 0 in DONE; no accept in the same cycle as the result handoff.
- Latency: accept edge E0; out_valid rises after E0 + k edges, where k = min(floor(lz/2)+1, WIDTH/2).
  - MSB set: out_valid high in the 2nd cycle after accept (k=1).
  - All-zero with WIDTH=32: k=16.
- Throughput: one op per (k+1+handshake) cycles; no overlap.
- flush: highest priority over all transitions.
  - Next edge: state=IDLE, out_valid=0, out_zero=0, count=0.
  - Operand offered in the same cycle is not accepted.
- Arithmetic: count is an unsigned CW-bit accumulator; it never exceeds WIDTH and cannot wrap.
- in_data is don't-care outside the accept edge; later changes do not affect the result.
- Reset mid-SCAN or mid-DONE: the result is discarded and outputs return to reset values immediately (async).
- Simultaneous in_valid and flush in IDLE: flush wins; no accept.
- Formal: cover out_valid & out_zero; assert out_count <= WIDTH; assert !(in_ready & out_valid).

Test Plan:
- WIDTH=32; in_data=0x8000_0000 -> out_count=0, out_zero=0, out_valid exactly 2 cycles after accept edge; busy high 2 cycles.
- in_data=0x4000_0000 -> out_count=1 after k=1; in_data=0x0000_0001 -> out_count=31, k=16; in_data=0x0010_0000 -> out_count=11, k=6.
- in_data=0x0000_0000 -> out_count=32, out_zero=1, out_valid 17 cycles after accept; next op 0xFFFF_FFFF -> out_count=0, out_zero=0 (flag cleared).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_count/out_zero stable, in_ready=0, busy=1; out_ready=1 -> out_valid drops next edge, in_ready=1 following cycle.
- Pull rst_n low at idx=3 of a 0x0000_0001 scan -> out_valid=0, busy=0 immediately; after release, 0x0800_0000 -> out_count=4.
- Assert flush in SCAN and in DONE (with in_valid=1 same cycle) -> IDLE next edge, no result emitted, no operand accepted; subsequent op completes normally.
